// File: rtl/split_join_nstack.sv
// Per-warp IPDOM divergence stacks: one split or join per cycle, with registered
// join results under backpressure, overflow/underflow error pulses and per-warp flush.
module split_join_nstack #(
  parameter int NUM_WARPS   = 4,
  parameter int THREAD_CNT  = 4,
  parameter int PC_W        = 32,
  parameter int STACK_DEPTH = 3,
  parameter int NW_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NW_W-1:0]              in_wid,
  input  logic                         split_valid,
  input  logic                         split_is_dvg,
  input  logic [THREAD_CNT-1:0]        split_then_tmask,
  input  logic [THREAD_CNT-1:0]        split_else_tmask,
  input  logic [PC_W-1:0]              split_next_pc,
  input  logic                         join_req,
  input  logic                         join_is_dvg_in,
  input  logic                         flush_valid,
  input  logic [NW_W-1:0]              flush_wid,
  output logic                         join_valid,
  input  logic                         join_ready,
  output logic                         join_is_dvg,
  output logic                         join_is_else,
  output logic [NW_W-1:0]              join_wid,
  output logic [THREAD_CNT-1:0]        join_tmask,
  output logic [PC_W-1:0]              join_pc,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic [NUM_WARPS*DEPTH_W-1:0] depth_dbg
);

  logic [DEPTH_W-1:0]     depth      [NUM_WARPS];
  logic [STACK_DEPTH-1:0] else_taken [NUM_WARPS];

  // Join-entry PC is always zero, so only its mask is stored.
  logic [THREAD_CNT-1:0] join_mem [NUM_WARPS][STACK_DEPTH];
  logic [THREAD_CNT-1:0] else_mem [NUM_WARPS][STACK_DEPTH];
  logic [PC_W-1:0]       pc_mem   [NUM_WARPS][STACK_DEPTH];

  logic                  accept, do_split, do_join;
  logic                  push, overflow, stack_hit, underflow;
  logic [DEPTH_W-1:0]    cur_depth, top;
  logic                  top_taken;
  logic [THREAD_CNT-1:0] res_tmask;
  logic [PC_W-1:0]       res_pc;

  assign in_ready  = !join_valid || join_ready;
  assign accept    = in_valid && in_ready;
  assign cur_depth = depth[in_wid];
  assign top       = cur_depth - DEPTH_W'(1);
  assign top_taken = else_taken[in_wid][top];

  assign do_split  = accept && split_valid;
  assign do_join   = accept && join_req && !split_valid;
  assign push      = do_split && split_is_dvg && (cur_depth < DEPTH_W'(STACK_DEPTH));
  assign overflow  = do_split && split_is_dvg && !(cur_depth < DEPTH_W'(STACK_DEPTH));
  assign stack_hit = do_join && join_is_dvg_in && (cur_depth != '0);
  assign underflow = (do_join && join_is_dvg_in && (cur_depth == '0))
                   || (accept && split_valid && join_req);

  always_comb begin
    res_tmask = '0;
    res_pc    = '0;
    if (join_is_dvg_in) begin
      if (cur_depth == '0) begin
        res_tmask = '1;
      end else if (!top_taken) begin
        res_tmask = else_mem[in_wid][top];
        res_pc    = pc_mem[in_wid][top];
      end else begin
        res_tmask = join_mem[in_wid][top];
      end
    end
  end

  // Flush is written last so it overrides a same-warp push/pop in that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        depth[w]      <= '0;
        else_taken[w] <= '0;
      end
    end else begin
      if (push) begin
        depth[in_wid]                <= cur_depth + DEPTH_W'(1);
        else_taken[in_wid][cur_depth] <= 1'b0;
      end else if (stack_hit && !top_taken) begin
        else_taken[in_wid][top] <= 1'b1;
      end else if (stack_hit) begin
        depth[in_wid] <= top;
      end
      if (flush_valid) depth[flush_wid] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      join_mem[in_wid][cur_depth] <= split_then_tmask | split_else_tmask;
      else_mem[in_wid][cur_depth] <= split_else_tmask;
      pc_mem[in_wid][cur_depth]   <= split_next_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      join_valid    <= 1'b0;
      join_is_dvg   <= 1'b0;
      join_is_else  <= 1'b0;
      join_wid      <= '0;
      join_tmask    <= '0;
      join_pc       <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= overflow;
      err_underflow <= underflow;
      if (do_join) begin
        join_valid   <= 1'b1;
        join_is_dvg  <= join_is_dvg_in;
        join_is_else <= stack_hit && !top_taken;
        join_wid     <= in_wid;
        join_tmask   <= res_tmask;
        join_pc      <= res_pc;
      end else if (join_ready) begin
        join_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    depth_dbg = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++)
      depth_dbg[w*DEPTH_W +: DEPTH_W] = depth[w];
  end

endmodule

// File: tb/tb_split_join_nstack.sv
// Directed bench for split_join_nstack: expected join results are queued when a
// join is driven and compared when the DUT hands the result over.
module tb_split_join_nstack;
  localparam int NW = 4, TC = 4, PW = 32, SD = 3, NWW = 2, DW = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0, split_valid = 1'b0, split_is_dvg = 1'b0;
  logic           join_req = 1'b0, join_is_dvg_in = 1'b0, flush_valid = 1'b0;
  logic           join_ready = 1'b1;
  logic [NWW-1:0] in_wid = '0, flush_wid = '0;
  logic [TC-1:0]  split_then_tmask = '0, split_else_tmask = '0;
  logic [PW-1:0]  split_next_pc = '0;
  logic           in_ready, join_valid, join_is_dvg, join_is_else;
  logic [NWW-1:0] join_wid;
  logic [TC-1:0]  join_tmask;
  logic [PW-1:0]  join_pc;
  logic           err_overflow, err_underflow;
  logic [NW*DW-1:0] depth_dbg;

  typedef struct packed {
    logic           dvg;
    logic           els;
    logic [NWW-1:0] wid;
    logic [TC-1:0]  tmask;
    logic [PW-1:0]  pc;
  } res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  split_join_nstack #(.NUM_WARPS(NW), .THREAD_CNT(TC), .PC_W(PW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid),
    .split_valid(split_valid), .split_is_dvg(split_is_dvg),
    .split_then_tmask(split_then_tmask), .split_else_tmask(split_else_tmask),
    .split_next_pc(split_next_pc), .join_req(join_req), .join_is_dvg_in(join_is_dvg_in),
    .flush_valid(flush_valid), .flush_wid(flush_wid), .join_valid(join_valid),
    .join_ready(join_ready), .join_is_dvg(join_is_dvg), .join_is_else(join_is_else),
    .join_wid(join_wid), .join_tmask(join_tmask), .join_pc(join_pc),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .depth_dbg(depth_dbg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic dvg, input logic els, input logic [NWW-1:0] wid,
                              input logic [TC-1:0] tmask, input logic [PW-1:0] pc);
    return {dvg, els, wid, tmask, pc};
  endfunction

  function automatic logic [63:0] depth_of(input int w);
    return 64'(depth_dbg[w*DW +: DW]);
  endfunction

  // Compare a result that the coming clock edge will consume, then advance one cycle.
  task automatic tick();
    res_t obs, e;
    if (join_valid && join_ready) begin
      obs = {join_is_dvg, join_is_else, join_wid, join_tmask, join_pc};
      if (sb.size() == 0) begin
        chk("join_unexpected", {63'b0, join_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("join_result", 64'(obs), 64'(e));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; split_valid = 1'b0; split_is_dvg = 1'b0;
    join_req = 1'b0; join_is_dvg_in = 1'b0; flush_valid = 1'b0;
  endtask

  task automatic split_op(input logic [NWW-1:0] w, input logic [TC-1:0] t,
                          input logic [TC-1:0] e, input logic [PW-1:0] pc);
    in_valid = 1'b1; in_wid = w; split_valid = 1'b1; split_is_dvg = 1'b1;
    split_then_tmask = t; split_else_tmask = e; split_next_pc = pc;
    tick();
    idle();
  endtask

  task automatic join_op(input logic [NWW-1:0] w, input logic dvg, input res_t exp);
    in_valid = 1'b1; in_wid = w; join_req = 1'b1; join_is_dvg_in = dvg;
    sb.push_back(exp);
    tick();
    idle();
  endtask

  task automatic flush_op(input logic [NWW-1:0] w);
    flush_valid = 1'b1; flush_wid = w;
    tick();
    idle();
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_join_valid", {63'b0, join_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_depth", 64'(depth_dbg), 64'd0);
    chk("rst_errs", {62'b0, err_overflow, err_underflow}, 64'd0);
    chk("rst_data", {join_is_dvg, join_is_else, join_wid, join_tmask, join_pc}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Nested divergence on warp 1
    split_op(2'd1, 4'b0011, 4'b1100, 32'h100);
    split_op(2'd1, 4'b0001, 4'b0010, 32'h200);
    chk("nest_depth_a", depth_of(1), 64'd2);
    join_op(2'd1, 1'b1, mk(1'b1, 1'b1, 2'd1, 4'b0010, 32'h200));
    chk("nest_depth_b", depth_of(1), 64'd2);
    join_op(2'd1, 1'b1, mk(1'b1, 1'b0, 2'd1, 4'b0011, 32'h0));
    chk("nest_depth_c", depth_of(1), 64'd1);
    join_op(2'd1, 1'b1, mk(1'b1, 1'b1, 2'd1, 4'b1100, 32'h100));
    chk("nest_depth_d", depth_of(1), 64'd1);
    join_op(2'd1, 1'b1, mk(1'b1, 1'b0, 2'd1, 4'b1111, 32'h0));
    chk("nest_depth_e", depth_of(1), 64'd0);
    tick();

    // Overflow on warp 0
    split_op(2'd0, 4'b0001, 4'b0010, 32'h10);
    split_op(2'd0, 4'b0100, 4'b1000, 32'h20);
    split_op(2'd0, 4'b0011, 4'b1100, 32'h30);
    chk("ovf_none_yet", {63'b0, err_overflow}, 64'd0);
    split_op(2'd0, 4'b1111, 4'b0000, 32'h40);
    chk("ovf_pulse", {63'b0, err_overflow}, 64'd1);
    chk("ovf_depth", depth_of(0), 64'd3);
    tick();
    chk("ovf_pulse_end", {63'b0, err_overflow}, 64'd0);
    join_op(2'd0, 1'b1, mk(1'b1, 1'b1, 2'd0, 4'b1100, 32'h30));
    chk("ovf_join_depth", depth_of(0), 64'd3);
    flush_op(2'd0);
    chk("flush_w0", depth_of(0), 64'd0);

    // Underflow on empty warp 2, then a non-divergent join
    join_op(2'd2, 1'b1, mk(1'b1, 1'b0, 2'd2, 4'b1111, 32'h0));
    chk("udf_pulse", {63'b0, err_underflow}, 64'd1);
    chk("udf_valid", {63'b0, join_valid}, 64'd1);
    tick();
    chk("udf_pulse_end", {63'b0, err_underflow}, 64'd0);
    join_op(2'd3, 1'b0, mk(1'b0, 1'b0, 2'd3, 4'b0000, 32'h0));
    chk("nodvg_depth", depth_of(3), 64'd0);
    tick();

    // Split and join together: split wins, join ignored, underflow flagged
    in_valid = 1'b1; in_wid = 2'd2; split_valid = 1'b1; split_is_dvg = 1'b1;
    join_req = 1'b1; join_is_dvg_in = 1'b1;
    split_then_tmask = 4'b0001; split_else_tmask = 4'b0010; split_next_pc = 32'h55;
    tick();
    idle();
    chk("both_udf", {63'b0, err_underflow}, 64'd1);
    chk("both_no_join", {63'b0, join_valid}, 64'd0);
    chk("both_depth", depth_of(2), 64'd1);
    flush_op(2'd2);
    chk("both_flush", depth_of(2), 64'd0);

    // Backpressure: first result held, second request waits at the input
    join_ready = 1'b0;
    in_valid = 1'b1; in_wid = 2'd1; join_req = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 2'd1, 4'b0000, 32'h0));
    tick();
    in_wid = 2'd3;
    sb.push_back(mk(1'b0, 1'b0, 2'd3, 4'b0000, 32'h0));
    chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    tick();
    chk("bp_hold_a", {61'b0, join_valid, join_wid}, {61'b0, 1'b1, 2'd1});
    tick();
    chk("bp_hold_b", {61'b0, join_valid, join_wid}, {61'b0, 1'b1, 2'd1});
    join_ready = 1'b1;
    tick();
    idle();
    chk("bp_second", {61'b0, join_valid, join_wid}, {61'b0, 1'b1, 2'd3});
    tick();
    chk("bp_drained", {63'b0, join_valid}, 64'd0);

    // Flush behaviour
    split_op(2'd3, 4'b0001, 4'b0010, 32'h300);
    chk("fl_push_w3", depth_of(3), 64'd1);
    flush_op(2'd3);
    chk("fl_w3", depth_of(3), 64'd0);
    flush_valid = 1'b1; flush_wid = 2'd3;
    split_op(2'd0, 4'b0110, 4'b1001, 32'h77);
    chk("fl_other_w0", depth_of(0), 64'd1);
    chk("fl_other_w3", depth_of(3), 64'd0);
    flush_valid = 1'b1; flush_wid = 2'd3;
    split_op(2'd3, 4'b0001, 4'b0010, 32'h333);
    chk("fl_override_push", depth_of(3), 64'd0);
    flush_valid = 1'b1; flush_wid = 2'd0;
    join_op(2'd0, 1'b1, mk(1'b1, 1'b1, 2'd0, 4'b1001, 32'h77));
    chk("fl_join_depth", depth_of(0), 64'd0);
    tick();

    // Asynchronous reset between clock edges
    split_op(2'd1, 4'b0011, 4'b1100, 32'h100);
    in_valid = 1'b1; in_wid = 2'd2; join_req = 1'b1;
    tick();
    idle();
    chk("ar_pre_valid", {63'b0, join_valid}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid_drop", {63'b0, join_valid}, 64'd0);
    chk("ar_depth_clr", 64'(depth_dbg), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("ar_post_depth", 64'(depth_dbg), 64'd0);
    chk("ar_post_ready", {63'b0, in_ready}, 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
